// File: rtl/embcpumem_jtag_debug_action_bridge.sv
`default_nettype none
// ============================================================================
// Module      : embcpumem_jtag_debug_action_bridge
// Description : Moves virtual-JTAG update-IR / update-DR events from the TCK
//               domain into clk. The instruction register selects an action
//               channel, and the captured data register (jdo) is handed to that
//               channel once it is ready. The strobe is take_action when the
//               jdo MSB is set and take_no_action when it is clear.
// Ports       : clk, reset       - system clock, async active-high reset
//               vs_uir, vs_udr   - TCK-domain update-IR / update-DR levels
//               ir_in, sr        - IR value / shift register (quasi-static)
//               ch_ready         - per-channel consumer ready
//               clr_err          - clears the sticky error flags
//               jdo              - captured data register
//               take_action      - one-cycle action strobe (one-hot)
//               take_no_action   - one-cycle no-action strobe (one-hot)
//               busy             - command in flight
//               overrun          - sticky: a udr update was dropped
//               parity_err       - sticky: a captured word had odd parity
// Options     : define EMBCPUMEM_JTAG_BRIDGE_PARITY_EN to enable the even-parity
//               check on jdo. Without it, parity_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module embcpumem_jtag_debug_action_bridge #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DR_W-1:0]   sr,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic              clr_err,
    output logic [DR_W-1:0]   jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              busy,
    output logic              overrun,
    output logic              parity_err
);

    localparam logic [31:0] c_num_ch = NUM_CH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PEND    = 2'd2,
        S_ISSUE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_uir_d;
    logic                   r_udr_d;
    logic                   r_uir_armed;
    logic                   r_udr_armed;

    logic [IR_W-1:0]        r_ir_q;
    logic [IR_W-1:0]        r_ch;
    logic [DR_W-1:0]        r_jdo;
    logic [NUM_CH-1:0]      r_take_action;
    logic [NUM_CH-1:0]      r_take_no_action;
    logic                   r_overrun;

    logic                   w_uir_lvl;
    logic                   w_udr_lvl;
    logic                   w_uir_evt;
    logic                   w_udr_evt;
    logic [IR_W-1:0]        w_ir_eff;
    logic                   w_ir_ok;
    logic                   w_ch_ready;
    logic [NUM_CH-1:0]      w_onehot;
    logic                   w_accept;
    logic                   w_issue;
    logic                   w_overrun_set;
`ifdef EMBCPUMEM_JTAG_BRIDGE_PARITY_EN
    logic                   r_parity_err;
    logic                   w_parity_set;
`endif

    // ------------------------------------------------------------------
    // Synchronisers and edge detection.
    // r_vld fills with ones after reset and marks the point where the
    // synchroniser outputs reflect real samples instead of reset zeros.
    // An edge detector is armed only after it has seen a genuine low
    // level. This keeps a level that is already high at reset release
    // from being taken as a fresh update.
    // ------------------------------------------------------------------
    assign w_uir_lvl = r_uir_sync[SYNC_STAGES-1];
    assign w_udr_lvl = r_udr_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_uir_sync  <= '0;
            r_udr_sync  <= '0;
            r_vld       <= '0;
            r_uir_d     <= 1'b0;
            r_udr_d     <= 1'b0;
            r_uir_armed <= 1'b0;
            r_udr_armed <= 1'b0;
        end else begin
            r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_uir_d     <= w_uir_lvl;
            r_udr_d     <= w_udr_lvl;
            r_uir_armed <= r_uir_armed | (r_vld[SYNC_STAGES-1] & ~w_uir_lvl);
            r_udr_armed <= r_udr_armed | (r_vld[SYNC_STAGES-1] & ~w_udr_lvl);
        end
    end

    assign w_uir_evt = r_uir_armed & w_uir_lvl & ~r_uir_d;
    assign w_udr_evt = r_udr_armed & w_udr_lvl & ~r_udr_d;

    // A uir event in the same cycle as a udr event is applied first, so
    // the udr command is decoded against the incoming IR value.
    assign w_ir_eff   = w_uir_evt ? ir_in : r_ir_q;
    assign w_ir_ok    = (32'(w_ir_eff) < c_num_ch);
    assign w_ch_ready = ch_ready[r_ch];

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_onehot[i] = (r_ch == IR_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
`ifdef EMBCPUMEM_JTAG_BRIDGE_PARITY_EN
        w_parity_set = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_udr_evt && w_ir_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
`ifdef EMBCPUMEM_JTAG_BRIDGE_PARITY_EN
                if (^r_jdo) begin
                    w_parity_set = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = w_ch_ready ? S_ISSUE : S_PEND;
                end
`else
                w_state_nxt = w_ch_ready ? S_ISSUE : S_PEND;
`endif
            end
            S_PEND: begin
                if (w_ch_ready) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A udr event that arrives while a command is in flight is dropped.
    assign w_overrun_set = w_udr_evt && (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Datapath, registered strobes and sticky flags.
    // The strobes are registered off the ISSUE state, so each pulse lasts
    // exactly one cycle and is driven glitch-free.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_q           <= '0;
            r_ch             <= '0;
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_overrun        <= 1'b0;
        end else begin
            if (w_uir_evt) begin
                r_ir_q <= ir_in;
            end
            if (w_accept) begin
                r_jdo <= sr;
                r_ch  <= w_ir_eff;
            end
            r_take_action    <= (w_issue &&  r_jdo[DR_W-1]) ? w_onehot : '0;
            r_take_no_action <= (w_issue && !r_jdo[DR_W-1]) ? w_onehot : '0;
            // A set in the same cycle wins over the clear.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef EMBCPUMEM_JTAG_BRIDGE_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if (w_parity_set) begin
            r_parity_err <= 1'b1;
        end else if (clr_err) begin
            r_parity_err <= 1'b0;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign busy           = (r_state != S_IDLE);
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_embcpumem_jtag_debug_action_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_embcpumem_jtag_debug_action_bridge
// Description : Directed self-checking bench for the JTAG debug action bridge.
//               The main instance uses the default parameters. A second
//               instance with NUM_CH=3 exercises out-of-range IR values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_embcpumem_jtag_debug_action_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vs_uir = 1'b0, vs_udr = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic [3:0]  ch_ready = 4'hF;
    logic        clr_err = 1'b0;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic        busy, overrun, parity_err;

    logic        vs_uir3 = 1'b0, vs_udr3 = 1'b0;
    logic [1:0]  ir_in3 = '0;
    logic [37:0] sr3 = '0;
    logic [2:0]  ch_ready3 = 3'b111;
    logic [37:0] jdo3;
    logic [2:0]  take_action3, take_no_action3;
    logic        busy3, overrun3, parity_err3;

    int checks = 0;
    int failures = 0;
    int n_act = 0, n_noact = 0, n3_act = 0, n3_noact = 0;
    logic [3:0] last_noact = '0;

    always #5 clk = ~clk;

    embcpumem_jtag_debug_action_bridge dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .ch_ready(ch_ready), .clr_err(clr_err),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    embcpumem_jtag_debug_action_bridge #(.IR_W(2), .DR_W(38), .NUM_CH(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir3), .vs_udr(vs_udr3),
        .ir_in(ir_in3), .sr(sr3), .ch_ready(ch_ready3), .clr_err(clr_err),
        .jdo(jdo3), .take_action(take_action3), .take_no_action(take_no_action3),
        .busy(busy3), .overrun(overrun3), .parity_err(parity_err3)
    );

    // Strobe counters and the at-most-one-strobe check, sampled mid-cycle.
    always @(negedge clk) begin
        if (take_action != 0) n_act++;
        if (take_no_action != 0) begin n_noact++; last_noact = take_no_action; end
        if (take_action3 != 0) n3_act++;
        if (take_no_action3 != 0) n3_noact++;
        checks++;
        if ($countones({take_action, take_no_action}) > 1) begin
            failures++;
            $display("FAIL strobe_onehot: act=%b noact=%b required at most one bit", take_action, take_no_action);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_act = 0; n_noact = 0; n3_act = 0; n3_noact = 0;
    endtask

    task automatic do_uir(input logic [1:0] v);
        ir_in = v; vs_uir = 1'b1; repeat (4) tick(); vs_uir = 1'b0; repeat (4) tick();
    endtask

    task automatic do_uir3(input logic [1:0] v);
        ir_in3 = v; vs_uir3 = 1'b1; repeat (4) tick(); vs_uir3 = 1'b0; repeat (4) tick();
    endtask

    task automatic do_udr(input logic [37:0] v);
        sr = v; vs_udr = 1'b1; repeat (6) tick(); vs_udr = 1'b0; repeat (4) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (jdo !== 38'h0) begin failures++; $display("FAIL reset_jdo: got %h want 0", jdo); end
        checks++; if ({take_action, take_no_action} !== 8'h0) begin failures++; $display("FAIL reset_strobes: got %h want 0", {take_action, take_no_action}); end
        checks++; if ({busy, overrun, parity_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {busy, overrun, parity_err}); end
        reset = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_action_latency();
        ch_ready = 4'hF;
        do_uir(2'd2);
        clear_counts();
        sr = 38'h20_0000_0001; vs_udr = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (take_action !== 4'h0) begin failures++; $display("FAIL action_early: edge %0d got %b want 0000", k, take_action); end
        end
        tick();
        checks++; if (take_action !== 4'b0100) begin failures++; $display("FAIL action_strobe: got %b want 0100", take_action); end
        checks++; if (jdo !== 38'h20_0000_0001) begin failures++; $display("FAIL action_jdo: got %h want 2000000001", jdo); end
        checks++; if (take_no_action !== 4'h0) begin failures++; $display("FAIL action_noact: got %b want 0000", take_no_action); end
        tick();
        checks++; if (take_action !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL action_end: act=%b busy=%b want 0000/0", take_action, busy); end
        vs_udr = 1'b0; repeat (4) tick();
        checks++; if (n_act !== 1 || n_noact !== 0) begin failures++; $display("FAIL action_count: act=%0d noact=%0d want 1/0", n_act, n_noact); end
    endtask

    task automatic test_pend();
        ch_ready = 4'b1101;
        do_uir(2'd1);
        clear_counts();
        sr = 38'h00_0000_00A5; vs_udr = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 3) vs_udr = 1'b0;
            checks++; if (busy !== 1'b1 || take_no_action !== 4'h0) begin failures++; $display("FAIL pend_wait: cycle %0d busy=%b noact=%b want 1/0000", k, busy, take_no_action); end
            tick();
        end
        ch_ready = 4'hF;
        tick();
        checks++; if (take_no_action !== 4'h0 || busy !== 1'b1) begin failures++; $display("FAIL pend_issue: noact=%b busy=%b want 0000/1", take_no_action, busy); end
        tick();
        checks++; if (take_no_action !== 4'b0010) begin failures++; $display("FAIL pend_strobe: got %b want 0010", take_no_action); end
        tick();
        checks++; if (take_no_action !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL pend_end: noact=%b busy=%b want 0000/0", take_no_action, busy); end
        checks++; if (n_noact !== 1 || n_act !== 0) begin failures++; $display("FAIL pend_count: noact=%0d act=%0d want 1/0", n_noact, n_act); end
    endtask

    task automatic test_overrun();
        ch_ready = 4'b1101;
        clear_counts();
        do_udr(38'h3);
        checks++; if (busy !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_pend: busy=%b overrun=%b want 1/0", busy, overrun); end
        sr = 38'hF; vs_udr = 1'b1; repeat (6) tick();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1", overrun); end
        checks++; if (jdo !== 38'h3) begin failures++; $display("FAIL ovr_jdo: got %h want 3", jdo); end
        vs_udr = 1'b0; repeat (4) tick();
        ch_ready = 4'hF; repeat (6) tick();
        checks++; if (n_noact !== 1 || n_act !== 0 || last_noact !== 4'b0010) begin failures++; $display("FAIL ovr_count: noact=%0d act=%0d last=%b want 1/0/0010", n_noact, n_act, last_noact); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_invalid_ch();
        ch_ready3 = 3'b111;
        clear_counts();
        do_uir3(2'd0);
        sr3 = 38'h5; vs_udr3 = 1'b1; repeat (6) tick(); vs_udr3 = 1'b0; repeat (4) tick();
        checks++; if (n3_noact !== 1 || jdo3 !== 38'h5) begin failures++; $display("FAIL inv_valid: noact=%0d jdo=%h want 1/5", n3_noact, jdo3); end
        do_uir3(2'd3);
        clear_counts();
        sr3 = 38'h20_0000_000A; vs_udr3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL inv_busy: cycle %0d got %b want 0", k, busy3); end
        end
        vs_udr3 = 1'b0; repeat (3) tick();
        checks++; if (jdo3 !== 38'h5) begin failures++; $display("FAIL inv_jdo: got %h want 5", jdo3); end
        checks++; if (n3_act + n3_noact !== 0 || overrun3 !== 1'b0) begin failures++; $display("FAIL inv_strobe: strobes=%0d overrun=%b want 0/0", n3_act + n3_noact, overrun3); end
    endtask

    task automatic test_reset_mid();
        ch_ready = 4'h0;
        do_uir(2'd1);
        sr = 38'h3F_0000_0000; vs_udr = 1'b1; repeat (6) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pend: busy=%b want 1", busy); end
        reset = 1'b1; #1;
        checks++; if ({busy, overrun, parity_err} !== 3'b000 || jdo !== 38'h0) begin failures++; $display("FAIL rst_async: flags=%b jdo=%h want 000/0", {busy, overrun, parity_err}, jdo); end
        checks++; if ({take_action, take_no_action} !== 8'h0) begin failures++; $display("FAIL rst_strobes: got %h want 0", {take_action, take_no_action}); end
        ch_ready = 4'hF;
        repeat (2) tick();
        reset = 1'b0;
        clear_counts();
        repeat (10) tick();
        checks++; if (busy !== 1'b0 || n_act + n_noact !== 0) begin failures++; $display("FAIL rst_release: busy=%b strobes=%0d want 0/0", busy, n_act + n_noact); end
        vs_udr = 1'b0; repeat (5) tick();
    endtask

    task automatic test_parity();
        ch_ready = 4'hF;
        do_uir(2'd1);
        clear_counts();
        do_udr(38'h1);
`ifdef EMBCPUMEM_JTAG_BRIDGE_PARITY_EN
        checks++; if (parity_err !== 1'b1 || n_act + n_noact !== 0 || busy !== 1'b0) begin failures++; $display("FAIL par_odd: perr=%b strobes=%0d busy=%b want 1/0/0", parity_err, n_act + n_noact, busy); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_clear: got %b want 0", parity_err); end
`else
        checks++; if (parity_err !== 1'b0 || n_noact !== 1 || n_act !== 0) begin failures++; $display("FAIL par_off: perr=%b noact=%0d act=%0d want 0/1/0", parity_err, n_noact, n_act); end
`endif
        clear_counts();
        do_udr(38'h3);
        checks++; if (n_noact !== 1 || last_noact !== 4'b0010 || parity_err !== 1'b0) begin failures++; $display("FAIL par_even: noact=%0d last=%b perr=%b want 1/0010/0", n_noact, last_noact, parity_err); end
        checks++; if (jdo !== 38'h3) begin failures++; $display("FAIL par_jdo: got %h want 3", jdo); end
    endtask

    initial begin
        test_reset();
        test_action_latency();
        test_pend();
        test_overrun();
        test_invalid_ch();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/embcpumem_jtag_debug_action_bridge.md
EMBCPUMEM_JTAG_DEBUG_ACTION_BRIDGE -- requirements
Module: embcpumem_jtag_debug_action_bridge

Interface
REQ-001 SHALL have parameter IR_W, default 2: width of the virtual-JTAG instruction register.
REQ-002 SHALL have parameter DR_W, default 38: width of the shift-register snapshot and of jdo.
REQ-003 SHALL have parameter NUM_CH, default 4: number of action channels; legal range is 1 to 2**IR_W.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, minimum 2.
REQ-005 SHALL have a single clock and an asynchronous, active-high reset: clk input 1 is the system clock; reset input 1 is the asynchronous active-high reset.
REQ-006 SHALL have the following ports:
- vs_uir  input  1  TCK-domain update-IR level, asynchronous to clk.
- vs_udr  input  1  TCK-domain update-DR level, asynchronous to clk.
- ir_in  input  IR_W  virtual IR value, stable while vs_uir is high.
- sr  input  DR_W  TCK-domain shift register, stable while vs_udr is high.
- ch_ready  input  NUM_CH  per-channel consumer ready.
- clr_err  input  1  single-cycle pulse that clears the sticky error flags.
- jdo  output  DR_W  captured data register.
- take_action  output  NUM_CH  one-cycle action strobe.
- take_no_action  output  NUM_CH  one-cycle no-action strobe.
- busy  output  1  high when the state is not IDLE.
- overrun  output  1  sticky: an update was dropped.
- parity_err  output  1  sticky: an update failed the parity check.

Function
REQ-007 SHALL synchronise vs_uir and vs_udr through SYNC_STAGES flops each, then detect each rising edge against a further registered copy.
REQ-008 SHALL, on a vs_uir rising-edge event, load ir_in into an internal ir_q; this produces no strobe.
REQ-009 SHALL, when uir and udr events occur in the same cycle, apply the uir event first, so the udr command uses the new ir_q.
REQ-010 SHALL use four states: IDLE, CAPTURE, PEND, ISSUE.
REQ-011 SHALL, in IDLE on a udr event with ir_q < NUM_CH: load jdo <= sr and channel register ch <= ir_q, and go to CAPTURE.
REQ-012 SHALL, in IDLE on a udr event with ir_q >= NUM_CH: ignore the event; jdo is unchanged and no error is flagged.
REQ-013 SHALL, in CAPTURE: go to ISSUE if ch_ready[ch] is high, else go to PEND.
REQ-014 SHALL, in PEND: wait indefinitely, and go to ISSUE in the cycle after ch_ready[ch] is sampled high.
REQ-015 SHALL, in ISSUE: assert take_action[ch] for exactly one cycle if jdo[DR_W-1] is 1, else take_no_action[ch], then return to IDLE.
REQ-016 SHALL assert at most one strobe bit of either vector in any cycle.
REQ-017 SHALL keep jdo stable from CAPTURE until the next accepted udr event.
REQ-018 SHALL have a latency of SYNC_STAGES+3 clk edges from the first clk edge sampling vs_udr high to the strobe being high, when ch_ready is already high.
REQ-019 SHALL, on a udr event in any state other than IDLE: drop the event, leave jdo and ch unchanged, and set overrun.
REQ-020 SHALL clear overrun and parity_err on clr_err; a set from the same cycle takes priority over the clear.
REQ-021 SHALL hold busy high in CAPTURE, PEND and ISSUE.

Reset
REQ-022 SHALL, while reset is asserted, asynchronously clear all flops: synchronisers, edge registers, ir_q, ch, jdo = 0, both strobe vectors = 0, busy = 0, overrun = 0, parity_err = 0, state = IDLE.
REQ-023 SHALL discard a pending or in-flight command when reset is asserted mid-operation, with no strobe after release.
REQ-024 SHALL, after reset release, ignore a vs_udr level that is already high until it has been seen low and then high again.

Configuration
REQ-025 SHALL, when EMBCPUMEM_JTAG_BRIDGE_PARITY_EN is defined, check in CAPTURE that the XOR of all DR_W bits of jdo is 0; on mismatch it sets parity_err, issues no strobe and returns to IDLE.
REQ-026 SHALL, when EMBCPUMEM_JTAG_BRIDGE_PARITY_EN is undefined, omit the parity logic, tie parity_err to 0, and follow REQ-013 unconditionally.

Verification
REQ-027 SHALL cover: defaults; uir with ir_in=2; udr with sr=38'h20_0000_0001 and ch_ready=4'hF -> jdo=38'h20_0000_0001 and take_action[2] high for one cycle, 5 edges after vs_udr is sampled high.
REQ-028 SHALL cover: ir_q=1 with ch_ready[1]=0 for 10 cycles, sr MSB=0 -> busy high throughout, then a single take_no_action[1] pulse one cycle after ch_ready[1] rises.
REQ-029 SHALL cover: a second udr event while in PEND -> overrun=1, jdo keeps the first value, exactly one strobe; then clr_err -> overrun=0.
REQ-030 SHALL cover: NUM_CH=3, IR_W=2, ir_q=3, udr event -> no strobe, jdo unchanged, busy stays 0.
REQ-031 SHALL cover: reset asserted during PEND -> all outputs 0 immediately; no strobe after release even with ch_ready=all-ones.
REQ-032 SHALL cover: with EMBCPUMEM_JTAG_BRIDGE_PARITY_EN defined, sr=38'h1 (odd parity) -> parity_err=1 and no strobe; sr=38'h3 -> strobe issued.
